reg_readout: RTL and testbench

Debug readout engine for the 4-bit CPU register bank. On a start request it snapshots all `NUM_REGS` registers in a single cycle. It then streams the captured values out one word at a time over a valid/ready handshake, in ascending register index order. It is the reading end of the register write path: it lets the narrow top-level I/O observe CPU state without disturbing it.

---
 rtl/reg_readout_if.sv | 26 ++
 rtl/reg_readout.sv | 66 ++++++
 tb/tb_reg_readout.sv | 256 +++++++++++++++++++++++++
 3 files changed

// File: rtl/reg_readout_if.sv
// Bundle of the readout engine's request, register-bank and streaming handshake signals.
// master = the readout engine, slave = the consumer/requester side.
interface reg_readout_if #(
    parameter int REGISTER_WIDTH = 4,
    parameter int NUM_REGS       = 4,
    parameter int IDX_W          = $clog2(NUM_REGS)
) ();
    logic                               start_i;
    logic [NUM_REGS*REGISTER_WIDTH-1:0] regs_i;
    logic [REGISTER_WIDTH-1:0]          data_o;
    logic [IDX_W-1:0]                   index_o;
    logic                               valid_o;
    logic                               ready_i;
    logic                               busy_o;
    logic                               done_o;

    modport master (
        input  start_i, regs_i, ready_i,
        output data_o, index_o, valid_o, busy_o, done_o
    );

    modport slave (
        output start_i, regs_i, ready_i,
        input  data_o, index_o, valid_o, busy_o, done_o
    );
endinterface

// File: rtl/reg_readout.sv
// Debug readout engine: snapshots the CPU register bank on start and streams
// the captured words out in ascending index order over valid/ready.
module reg_readout #(
    parameter int REGISTER_WIDTH = 4,
    parameter int NUM_REGS       = 4,
    parameter int IDX_W          = $clog2(NUM_REGS)
) (
    input  logic          clk_i,
    input  logic          reset_i,
    reg_readout_if.master bus
);
    localparam logic [1:0]       S_IDLE   = 2'd0;
    localparam logic [1:0]       S_SEND   = 2'd1;
    localparam logic [1:0]       S_DONE   = 2'd2;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);

    logic [1:0]                                r_state;
    logic [IDX_W-1:0]                          r_idx;
    logic [NUM_REGS-1:0][REGISTER_WIDTH-1:0]   r_snap;
    logic                                      w_send;
    logic                                      w_xfer;
    logic                                      w_last;

    assign w_send = (r_state == S_SEND);
    assign w_xfer = w_send && bus.ready_i;
    assign w_last = (r_idx == LAST_IDX);

    // The snapshot is only written on an accepted start, so regs_i changes
    // during a stream never leak into the streamed words.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_state <= S_IDLE;
            r_idx   <= '0;
            r_snap  <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start_i) begin
                        r_snap  <= bus.regs_i;
                        r_idx   <= '0;
                        r_state <= S_SEND;
                    end
                end
                S_SEND: begin
                    if (w_xfer) begin
                        if (w_last) begin
                            r_idx   <= '0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx <= r_idx + 1'b1;
                        end
                    end
                end
                S_DONE:  r_state <= S_IDLE;
                default: r_state <= S_IDLE;
            endcase
        end
    end

    // Outputs decode straight from state so an async reset clears them at once.
    assign bus.valid_o = w_send;
    assign bus.busy_o  = w_send || (r_state == S_DONE);
    assign bus.done_o  = (r_state == S_DONE);
    assign bus.index_o = r_idx;
    assign bus.data_o  = w_send ? r_snap[r_idx] : '0;
endmodule

// File: tb/tb_reg_readout.sv
// Scoreboard bench for reg_readout: stimulus pushes expected words, a negedge
// monitor pops and compares every accepted word and checks stall stability.
module tb_reg_readout;
    localparam int W  = 4;
    localparam int N  = 4;
    localparam int IW = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    reg_readout_if #(.REGISTER_WIDTH(W), .NUM_REGS(N)) bus ();

    reg_readout #(.REGISTER_WIDTH(W), .NUM_REGS(N)) dut (
        .clk_i   (clk),
        .reset_i (rst),
        .bus     (bus)
    );

    typedef struct packed {
        logic [IW-1:0] idx;
        logic [W-1:0]  data;
    } word_t;

    word_t exp_q[$];
    int    total = 0;
    int    bad   = 0;
    int    cyc   = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Monitor: pops on every transfer, checks a stalled word is held unchanged.
    logic  stalled = 1'b0;
    word_t held;
    always @(negedge clk) begin
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("stall_valid", bus.valid_o, 1);
                chk("stall_index", bus.index_o, held.idx);
                chk("stall_data",  bus.data_o,  held.data);
            end
            stalled = 1'b0;
            if (bus.valid_o === 1'b1) begin
                if (bus.ready_i === 1'b1) begin
                    if (exp_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL unexpected_word: got idx=%0d data=%0h, expected no word (cycle %0d)",
                                 bus.index_o, bus.data_o, cyc);
                    end else begin
                        word_t e;
                        e = exp_q.pop_front();
                        chk("word_index", bus.index_o, e.idx);
                        chk("word_data",  bus.data_o,  e.data);
                    end
                end else begin
                    stalled   = 1'b1;
                    held.idx  = bus.index_o;
                    held.data = bus.data_o;
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_stream(input logic [15:0] r);
        for (int k = 0; k < N; k++) begin
            word_t w;
            w.idx  = IW'(k);
            w.data = r[k*W +: W];
            exp_q.push_back(w);
        end
    endtask

    task automatic wait_done(input string name, output int dc);
        dc = -1;
        for (int n = 0; n < 50; n++) begin
            @(negedge clk);
            #1;
            if (bus.done_o === 1'b1) begin
                dc = cyc;
                break;
            end
        end
        if (dc < 0) begin
            total++;
            bad++;
            $display("FAIL %s: got no done_o within 50 cycles, expected a done pulse", name);
        end
    endtask

    task automatic chk_outputs_zero(input string name);
        chk({name, "_valid"}, bus.valid_o, 0);
        chk({name, "_busy"},  bus.busy_o,  0);
        chk({name, "_done"},  bus.done_o,  0);
        chk({name, "_index"}, bus.index_o, 0);
        chk({name, "_data"},  bus.data_o,  0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int         e;
        int         d;
        int         d2;
        logic [6:0] pat;

        bus.start_i = 1'b0;
        bus.ready_i = 1'b0;
        bus.regs_i  = 16'hFFFF;
        #3;
        chk_outputs_zero("reset");
        tick();
        tick();
        rst = 1'b0;

        // 1: basic stream
        tick();
        bus.regs_i  = 16'hDCBA;
        bus.start_i = 1'b1;
        bus.ready_i = 1'b1;
        push_stream(16'hDCBA);
        e = cyc + 1;
        tick();
        bus.start_i = 1'b0;
        wait_done("s1_done", d);
        chk("s1_done_cycle", d, e + 4);
        chk("s1_q_empty", exp_q.size(), 0);
        @(negedge clk);
        #1;
        chk("s1_busy_after", bus.busy_o, 0);

        // 2: snapshot isolation
        tick();
        bus.regs_i  = 16'hDCBA;
        bus.start_i = 1'b1;
        push_stream(16'hDCBA);
        e = cyc + 1;
        tick();
        bus.start_i = 1'b0;
        bus.regs_i  = 16'h1234;
        wait_done("s2_done", d);
        chk("s2_done_cycle", d, e + 4);
        chk("s2_q_empty", exp_q.size(), 0);

        // 3: backpressure pattern 1,0,0,1,1,0,1
        pat = 7'b1011001;
        tick();
        bus.regs_i  = 16'hDCBA;
        bus.start_i = 1'b1;
        bus.ready_i = pat[0];
        push_stream(16'hDCBA);
        e = cyc + 1;
        tick();
        bus.start_i = 1'b0;
        for (int i = 1; i < 7; i++) begin
            tick();
            bus.ready_i = pat[i];
        end
        wait_done("s3_done", d);
        chk("s3_done_cycle", d, e + 7);
        chk("s3_q_empty", exp_q.size(), 0);
        bus.ready_i = 1'b1;

        // 4: start held high: one stream, DONE, one IDLE cycle, then a new stream
        tick();
        bus.regs_i  = 16'hDCBA;
        bus.start_i = 1'b1;
        push_stream(16'hDCBA);
        push_stream(16'hDCBA);
        e = cyc + 1;
        wait_done("s4_done1", d);
        chk("s4_done1_cycle", d, e + 4);
        wait_done("s4_done2", d2);
        chk("s4_done2_cycle", d2, e + 10);
        bus.start_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            #1;
            chk("s4_no_restart", bus.valid_o, 0);
        end
        chk("s4_q_empty", exp_q.size(), 0);

        // 5: async reset mid-stream, just after index 1 is accepted
        tick();
        bus.regs_i  = 16'hDCBA;
        bus.start_i = 1'b1;
        push_stream(16'hDCBA);
        void'(exp_q.pop_back());
        void'(exp_q.pop_back());
        e = cyc + 1;
        tick();
        bus.start_i = 1'b0;
        tick();
        tick();
        #1;
        rst = 1'b1;
        #1;
        chk_outputs_zero("s5_reset");
        chk("s5_q_empty", exp_q.size(), 0);
        bus.regs_i = 16'h5678;
        tick();
        #2;
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            #1;
            chk("s5_quiet_valid", bus.valid_o, 0);
            chk("s5_quiet_done",  bus.done_o,  0);
        end
        tick();
        bus.start_i = 1'b1;
        push_stream(16'h5678);
        e = cyc + 1;
        tick();
        bus.start_i = 1'b0;
        wait_done("s5_done", d);
        chk("s5_done_cycle", d, e + 4);
        chk("s5_q_empty2", exp_q.size(), 0);

        // 6: idle quiet with toggling ready/regs
        for (int i = 0; i < 10; i++) begin
            tick();
            bus.ready_i = i[0];
            bus.regs_i  = 16'(i * 16'h1111);
            @(negedge clk);
            #1;
            chk("s6_valid", bus.valid_o, 0);
            chk("s6_busy",  bus.busy_o,  0);
            chk("s6_done",  bus.done_o,  0);
            chk("s6_index", bus.index_o, 0);
        end

        chk("final_q_empty", exp_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
